// File: rtl/fpm_pkg.sv
// Shared definitions for the FP multiplier exponent path: default widths,
// accumulator width derivation and the sequencer state encoding.
package fpm_pkg;

    localparam int FPM_EXP_W = 5;
    localparam int FPM_BIAS  = 15;

    // Accumulator needs one bit for the a+b carry and one for the sign after -BIAS.
    function automatic int fpm_add_w(input int exp_w);
        return exp_w + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_BIAS = 3'd2,
        ST_NORM = 3'd3,
        ST_DONE = 3'd4
    } fpm_state_e;

endpackage

// File: rtl/fpm_exp_adder.sv
// The single shared exponent adder: sum = a + b + cin, purely combinational.
module fpm_exp_adder #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/fpm_exp_sequencer.sv
// Exponent sequencer for the FP multiplier: a+b, -BIAS, +normalise shift on one
// shared adder, then saturate and flag. Optional zero bypass: FPM_EXP_ZERO_BYPASS_EN.
module fpm_exp_sequencer
    import fpm_pkg::*;
#(
    parameter int EXP_W = FPM_EXP_W,
    parameter int BIAS  = FPM_BIAS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             norm_valid,
    input  logic             norm_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             ovf,
    output logic             unf,
    output logic             busy
);

    localparam int ADD_W = fpm_add_w(EXP_W);
    localparam logic signed [ADD_W-1:0] EXP_MAX  = ADD_W'((1 << EXP_W) - 1);
    localparam logic        [ADD_W-1:0] BIAS_INV = ~ADD_W'(BIAS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid, once raised, holds with its data stable until that edge.

    fpm_state_e state_q, state_d;

    logic [ADD_W-1:0] op_a_q, op_b_q, acc_q;
    logic [EXP_W-1:0] exp_out_q;
    logic             ovf_q, unf_q;

    logic [ADD_W-1:0]        add_a, add_b, add_sum;
    logic                    add_cin;
    logic                    accept;
    logic signed [ADD_W-1:0] final_acc;
    logic                    ovf_d, unf_d;
    logic [EXP_W-1:0]        exp_d;

`ifdef FPM_EXP_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (exp_a == '0) || (exp_b == '0);
`endif

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign exp_out   = exp_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    fpm_exp_adder #(.W(ADD_W)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    always_comb begin
        state_d = state_q;
        add_a   = acc_q;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef FPM_EXP_ZERO_BYPASS_EN
                    state_d = zero_op ? ST_DONE : ST_ADD;
`else
                    state_d = ST_ADD;
`endif
                end
            end
            ST_ADD: begin
                add_a   = op_a_q;
                add_b   = op_b_q;
                state_d = ST_BIAS;
            end
            ST_BIAS: begin
                // Subtract BIAS as ~BIAS + 1, the +1 coming in on the carry.
                add_b   = BIAS_INV;
                add_cin = 1'b1;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                add_cin = norm_shift;
                if (norm_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flags are judged on the signed value the NORM step is about to store.
    always_comb begin
        final_acc = $signed(add_sum);
        ovf_d     = (final_acc >= EXP_MAX);
        unf_d     = final_acc[ADD_W-1] || (final_acc == '0);
        exp_d     = add_sum[EXP_W-1:0];
        if (ovf_d) exp_d = '1;
        else if (unf_d) exp_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            exp_out_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q <= {{(ADD_W-EXP_W){1'b0}}, exp_a};
                        op_b_q <= {{(ADD_W-EXP_W){1'b0}}, exp_b};
`ifdef FPM_EXP_ZERO_BYPASS_EN
                        if (zero_op) begin
                            exp_out_q <= '0;
                            ovf_q     <= 1'b0;
                            unf_q     <= 1'b1;
                        end
`endif
                    end
                end
                ST_ADD, ST_BIAS: acc_q <= add_sum;
                ST_NORM: begin
                    if (norm_valid) begin
                        acc_q     <= add_sum;
                        exp_out_q <= exp_d;
                        ovf_q     <= ovf_d;
                        unf_q     <= unf_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
